// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the IF/ID/EX pipeline sequencer.
//            Sequencer state encoding, the NOP instruction the flushed
//            pipeline registers emit, and the default reset/trap vectors.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    PC_ST_BOOT  = 2'd0,
    PC_ST_RUN   = 2'd1,
    PC_ST_STALL = 2'd2,
    PC_ST_FAULT = 2'd3
  } pc_state_t;

  // Instruction injected by if_id / id_ex when their flush strobe is high
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Default vectors used by the top-level parameters
  localparam logic [31:0] PC_RESET_ADDR_DFLT = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_ADDR_DFLT  = 32'h0000_0100;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : Request/command bundle between the pipeline sequencer and the
//            core. The sequencer uses the slave modport, the core (or a
//            testbench) the master modport.
//            Optional macro PIPE_CTRL_PERF_EN adds the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;

  // Requests from EX and the memory bus
  logic        ex_jump_en;
  logic [31:0] ex_jump_addr;
  logic        ex_hold_req;
  logic        bus_hold_req;

  // Commands towards the PC and the pipeline registers
  logic        pc_hold_en;
  logic        pc_load_en;
  logic [31:0] pc_load_addr;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        fault_o;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_events;
`endif

  // Sequencer side
  modport slave (
    input  ex_jump_en,
    input  ex_jump_addr,
    input  ex_hold_req,
    input  bus_hold_req,
    output pc_hold_en,
    output pc_load_en,
    output pc_load_addr,
    output if_id_flush,
    output id_ex_flush,
`ifdef PIPE_CTRL_PERF_EN
    output perf_stall_cycles,
    output perf_flush_events,
`endif
    output fault_o
  );

  // Core side
  modport master (
    output ex_jump_en,
    output ex_jump_addr,
    output ex_hold_req,
    output bus_hold_req,
    input  pc_hold_en,
    input  pc_load_en,
    input  pc_load_addr,
    input  if_id_flush,
    input  id_ex_flush,
`ifdef PIPE_CTRL_PERF_EN
    input  perf_stall_cycles,
    input  perf_flush_events,
`endif
    input  fault_o
  );

endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_stall_timer
// Brief    : Consecutive-stall counter with timeout compare. Counts every
//            cycle the PC is held, clears on request, saturates at
//            MAX_STALL and never wraps. o_expired flags the cycle whose
//            increment brings the count to MAX_STALL-1.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stall_timer #(
  parameter int MAX_STALL = 1024,
  parameter int CNT_W     = $clog2(MAX_STALL + 1)
) (
  input  wire logic sys_clk,
  input  wire logic sys_rst,
  input  wire logic i_clr,
  input  wire logic i_inc,
  output logic      o_expired
);

  // Saturation value and the pre-increment count that triggers the timeout
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] c_fault_at = CNT_W'(MAX_STALL - 2);

  logic [CNT_W-1:0] r_cnt;

  // Stall counter: clear wins over increment, holds at the saturation value
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Timeout only matters in a cycle that is itself a stall cycle
  assign o_expired = i_inc && (r_cnt >= c_fault_at);

endmodule : pipe_ctrl_stall_timer
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline sequencer for the 3-stage IF/ID/EX core. Merges EX
//            jump requests with EX/bus hold requests into PC hold/load
//            commands and per-stage flush strobes. A jump raised during a
//            stall is latched and replayed on release; a stall longer than
//            the timeout forces a trap load and sets a sticky fault flag.
//            All outputs are combinational from registered state + inputs.
//            Optional macro PIPE_CTRL_PERF_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = PC_RESET_ADDR_DFLT,
  parameter logic [31:0] TRAP_ADDR  = PC_TRAP_ADDR_DFLT,
  parameter int          MAX_STALL  = 1024,
  parameter int          CNT_W      = $clog2(MAX_STALL + 1)
) (
  input  wire logic  sys_clk,
  input  wire logic  sys_rst,
  pipe_ctrl_if.slave if_pipe
);

  // Registered state
  pc_state_t   r_state;
  logic        r_pend;
  logic [31:0] r_pend_addr;
  logic        r_fault;

  // Next-state and command wires
  pc_state_t   w_state_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_pend_addr_nxt;
  logic        w_hold;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_expired;
  logic        w_hold_en;
  logic        w_load_en;
  logic [31:0] w_load_addr;
  logic        w_if_id_flush;
  logic        w_id_ex_flush;

  assign w_hold = if_pipe.ex_hold_req | if_pipe.bus_hold_req;

  pipe_ctrl_stall_timer #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_stall_timer (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .i_clr     (w_cnt_clr),
    .i_inc     (w_cnt_inc),
    .o_expired (w_expired)
  );

  // State register, pending-jump latch and sticky fault flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= PC_ST_BOOT;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      if (r_state == PC_ST_FAULT) begin
        r_fault <= 1'b1;
      end
    end
  end

  // Next-state and command decode; hold has priority over any jump
  always_comb begin
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_hold_en       = 1'b0;
    w_load_en       = 1'b0;
    w_load_addr     = '0;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;

    case (r_state)
      PC_ST_BOOT: begin
        w_load_en     = 1'b1;
        w_load_addr   = RESET_ADDR;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        w_pend_nxt    = 1'b0;
        w_cnt_clr     = 1'b1;
        w_state_nxt   = PC_ST_RUN;
      end

      PC_ST_RUN, PC_ST_STALL: begin
        if (w_hold) begin
          // Freeze PC, bubble into ID; the instruction in ID stays put
          w_hold_en     = 1'b1;
          w_if_id_flush = 1'b1;
          w_cnt_inc     = 1'b1;
          if (if_pipe.ex_jump_en) begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = if_pipe.ex_jump_addr;
          end
          if ((r_state == PC_ST_STALL) && w_expired) begin
            w_state_nxt = PC_ST_FAULT;
          end else begin
            w_state_nxt = PC_ST_STALL;
          end
        end else begin
          // Running (or release cycle): a live jump beats a latched one
          if (if_pipe.ex_jump_en) begin
            w_load_en     = 1'b1;
            w_load_addr   = if_pipe.ex_jump_addr;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (r_pend) begin
            w_load_en     = 1'b1;
            w_load_addr   = r_pend_addr;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end
          w_pend_nxt  = 1'b0;
          w_cnt_clr   = 1'b1;
          w_state_nxt = PC_ST_RUN;
        end
      end

      PC_ST_FAULT: begin
        w_load_en     = 1'b1;
        w_load_addr   = TRAP_ADDR;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        w_pend_nxt    = 1'b0;
        w_cnt_clr     = 1'b1;
        w_state_nxt   = PC_ST_RUN;
      end

      default: begin
        w_state_nxt = PC_ST_BOOT;
      end
    endcase
  end

  assign if_pipe.pc_hold_en   = w_hold_en;
  assign if_pipe.pc_load_en   = w_load_en;
  assign if_pipe.pc_load_addr = w_load_addr;
  assign if_pipe.if_id_flush  = w_if_id_flush;
  assign if_pipe.id_ex_flush  = w_id_ex_flush;
  // Fault is visible already in the trap cycle, then held by the register
  assign if_pipe.fault_o      = r_fault | (r_state == PC_ST_FAULT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Free-running event counters, wrap modulo 2^32
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_hold_en) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_id_ex_flush) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign if_pipe.perf_stall_cycles = r_perf_stall;
  assign if_pipe.perf_flush_events = r_perf_flush;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed testbench for pipe_ctrl (MAX_STALL = 8). Inputs change
//            1 time unit after the rising edge, outputs are sampled on the
//            falling edge. Expected rows are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl_if u_if ();

  pipe_ctrl #(
    .RESET_ADDR (32'h0000_0000),
    .TRAP_ADDR  (32'h0000_0100),
    .MAX_STALL  (8)
  ) u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .if_pipe (u_if.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Observed row: {hold, load, addr[31:0], if_id_flush, id_ex_flush, fault}
  logic [36:0] w_obs;
  assign w_obs = {u_if.pc_hold_en, u_if.pc_load_en, u_if.pc_load_addr,
                  u_if.if_id_flush, u_if.id_ex_flush, u_if.fault_o};

  function automatic logic [36:0] exp_row(input logic h, input logic l,
                                          input logic [31:0] a, input logic fi,
                                          input logic fe, input logic f);
    return {h, l, a, fi, fe, f};
  endfunction

  task automatic drive(input logic j, input logic [31:0] a,
                       input logic eh, input logic bh);
    u_if.ex_jump_en   = j;
    u_if.ex_jump_addr = a;
    u_if.ex_hold_req  = eh;
    u_if.bus_hold_req = bh;
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [36:0] e;
    sys_rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    @(negedge sys_clk);
    e = exp_row(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", w_obs, e);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_tests++;
    if ({u_if.perf_stall_cycles, u_if.perf_flush_events} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %h/%h want 0/0", u_if.perf_stall_cycles, u_if.perf_flush_events);
    end
`endif
    next_cycle();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL boot_cycle: got %h want %h", w_obs, e);
    end
    next_cycle();
    @(negedge sys_clk);
    e = '0;
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL run_idle: got %h want %h", w_obs, e);
    end
    next_cycle();
  endtask

  task automatic test_jump();
    logic [36:0] e;
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    @(negedge sys_clk);
    e = exp_row(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL jump_load: got %h want %h", w_obs, e);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge sys_clk);
    e = '0;
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL jump_after: got %h want %h", w_obs, e);
    end
    next_cycle();
  endtask

  task automatic test_stall_pend();
    logic [36:0] e;
    for (int i = 1; i <= 5; i++) begin
      drive(i == 2, (i == 2) ? 32'h80 : 32'h0, 1'b0, 1'b1);
      @(negedge sys_clk);
      e = exp_row(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %h want %h", i, w_obs, e);
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge sys_clk);
    e = exp_row(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", w_obs, e);
    end
    next_cycle();
    @(negedge sys_clk);
    e = '0;
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL stall_after: got %h want %h", w_obs, e);
    end
    next_cycle();
  endtask

  task automatic test_newest_wins();
    logic [36:0] e;
    e = exp_row(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h80, 1'b1, 1'b0);
    @(negedge sys_clk);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL newest_stall1: got %h want %h", w_obs, e);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge sys_clk);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL newest_stall2: got %h want %h", w_obs, e);
    end
    next_cycle();
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    @(negedge sys_clk);
    e = exp_row(1'b0, 1'b1, 32'hC0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL newest_release: got %h want %h", w_obs, e);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge sys_clk);
    e = '0;
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL newest_no_replay: got %h want %h", w_obs, e);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic [36:0] e;
    for (int c = 1; c <= 17; c++) begin
      drive(1'b0, 32'h0, c <= 16, 1'b0);
      if (c == 8 || c == 16)
        e = exp_row(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
      else if (c == 17)
        e = exp_row(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      else
        e = exp_row(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, c > 8);
      @(negedge sys_clk);
      n_tests++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL timeout_c%0d: got %h want %h", c, w_obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [36:0] e;
    drive(1'b1, 32'hA0, 1'b1, 1'b0);
    @(negedge sys_clk);
    e = exp_row(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL rst_stall_pend: got %h want %h", w_obs, e);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    sys_rst = 1'b1;
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge sys_clk);
    e = exp_row(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL rst_mid_held: got %h want %h", w_obs, e);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_tests++;
    if ({u_if.perf_stall_cycles, u_if.perf_flush_events} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mid_perf: got %h/%h want 0/0", u_if.perf_stall_cycles, u_if.perf_flush_events);
    end
`endif
    next_cycle();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL rst_mid_boot: got %h want %h", w_obs, e);
    end
    e = '0;
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      @(negedge sys_clk);
      n_tests++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL rst_mid_no_replay_%0d: got %h want %h", k, w_obs, e);
      end
    end
    next_cycle();
  endtask

  initial begin
    sys_rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_jump();
    test_stall_pend();
    test_newest_wins();
    test_timeout();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
